seq_divider: RTL and testbench

Sequential 32-bit integer divider, the inverse-operation companion to the adder and multiplier blocks on the chip. It computes quotient and remainder with a restoring shift-subtract loop, one bit per clock. The subtract step reuses the existing 32-bit carry-bypass adder. A start/busy/done handshake lets a controller or bench issue one division at a time.

---
 rtl/seq_divider_pkg.sv | 14 +
 rtl/seq_divider_cba.sv | 40 ++++
 rtl/seq_divider.sv | 152 +++++++++++++++
 tb/tb_seq_divider.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/seq_divider_pkg.sv
// Shared constants and state encoding for the sequential divider.
package seq_divider_pkg;
  localparam int unsigned WIDTH = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREP,
    ST_CALC,
    ST_FIX,
    ST_DONE
  } state_e;

  localparam logic [WIDTH-1:0] DZ_QUOTIENT = 32'hFFFF_FFFF;
endpackage

// File: rtl/seq_divider_cba.sv
// 32-bit carry-bypass adder: 4-bit ripple blocks, each skipped when fully propagating.
module seq_divider_cba
  import seq_divider_pkg::*;
(
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o,
  output logic             of_o
);

  logic [WIDTH-1:0] p;
  logic [WIDTH-1:0] g;
  logic             c;
  logic             c_blk;
  logic             c_msb;

  assign p = a_i ^ b_i;
  assign g = a_i & b_i;

  always_comb begin
    c     = cin_i;
    c_blk = cin_i;
    c_msb = cin_i;
    sum_o = '0;
    for (int blk = 0; blk < 8; blk++) begin
      c_blk = c;
      for (int k = 0; k < 4; k++) begin
        if (4 * blk + k == 31) c_msb = c_blk;
        sum_o[4*blk+k] = p[4*blk+k] ^ c_blk;
        c_blk          = g[4*blk+k] | (p[4*blk+k] & c_blk);
      end
      c = (&p[4*blk +: 4]) ? c : c_blk;
    end
    cout_o = c;
    of_o   = c_msb ^ c;
  end

endmodule

// File: rtl/seq_divider.sv
// Restoring shift-subtract divider, one quotient bit per clock, with
// start/busy/done handshake and optional two's-complement operation.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter bit SIGNED = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] quotient_o,
  output logic [WIDTH-1:0] remainder_o,
  output logic             dz_o,
  output logic             of_o
);

  state_e           state_q, state_d;
  logic [4:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [WIDTH-1:0] qt_q, qt_d;
  logic             sa_q, sa_d;
  logic             sd_q, sd_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dz_q, dz_d;
  logic             of_q, of_d;

  logic [WIDTH-1:0] rs;
  logic [WIDTH-1:0] diff;
  logic             carry;
  logic             cba_of_unused;

  // a_q is shifted left each iteration, so its MSB is always the next dividend bit.
  assign rs = {r_q[WIDTH-2:0], a_q[WIDTH-1]};

  seq_divider_cba u_cba (
    .a_i   (rs),
    .b_i   (~d_q),
    .cin_i (1'b1),
    .sum_o (diff),
    .cout_o(carry),
    .of_o  (cba_of_unused)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    d_d     = d_q;
    r_d     = r_q;
    qt_d    = qt_q;
    sa_d    = sa_q;
    sd_d    = sd_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dz_d    = dz_q;
    of_d    = of_q;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          a_d     = dividend_i;
          d_d     = divisor_i;
          dz_d    = 1'b0;
          of_d    = 1'b0;
          state_d = ST_PREP;
        end
      end
      ST_PREP: begin
        if (d_q == '0) begin
          quo_d   = DZ_QUOTIENT;
          rem_d   = a_q;
          dz_d    = 1'b1;
          state_d = ST_DONE;
        end else begin
          sa_d    = SIGNED & a_q[WIDTH-1];
          sd_d    = SIGNED & d_q[WIDTH-1];
          a_d     = sa_d ? -a_q : a_q;
          d_d     = sd_d ? -d_q : d_q;
          r_d     = '0;
          qt_d    = '0;
          cnt_d   = 5'd31;
          state_d = ST_CALC;
        end
      end
      ST_CALC: begin
        if (r_q[WIDTH-1] | carry) begin
          r_d  = diff;
          qt_d = {qt_q[WIDTH-2:0], 1'b1};
        end else begin
          r_d  = rs;
          qt_d = {qt_q[WIDTH-2:0], 1'b0};
        end
        a_d   = {a_q[WIDTH-2:0], 1'b0};
        cnt_d = cnt_q - 5'd1;
        if (cnt_q == 5'd0) state_d = ST_FIX;
      end
      ST_FIX: begin
        quo_d   = (sa_q ^ sd_q) ? -qt_q : qt_q;
        rem_d   = sa_q ? -r_q : r_q;
        // Only |min_int| / |-1| yields a magnitude of 2^31 with both signs negative.
        of_d    = sa_q & sd_q & (qt_q == 32'h8000_0000);
        state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      d_q     <= '0;
      r_q     <= '0;
      qt_q    <= '0;
      sa_q    <= 1'b0;
      sd_q    <= 1'b0;
      quo_q   <= '0;
      rem_q   <= '0;
      dz_q    <= 1'b0;
      of_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      d_q     <= d_d;
      r_q     <= r_d;
      qt_q    <= qt_d;
      sa_q    <= sa_d;
      sd_q    <= sd_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dz_q    <= dz_d;
      of_q    <= of_d;
    end
  end

  assign busy_o      = (state_q == ST_PREP) || (state_q == ST_CALC) || (state_q == ST_FIX);
  assign done_o      = (state_q == ST_DONE);
  assign quotient_o  = quo_q;
  assign remainder_o = rem_q;
  assign dz_o        = dz_q;
  assign of_o        = of_q;

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: signed and unsigned instances, reference
// results from plain SV arithmetic, monitors pop expectations on done.
module tb_seq_divider;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
    logic        of;
    int unsigned e0;
    int unsigned lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int unsigned cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic        s_start = 1'b0, u_start = 1'b0;
  logic [31:0] s_a = '0, s_b = '0, u_a = '0, u_b = '0;
  logic        s_busy, s_done, s_dz, s_of, u_busy, u_done, u_dz, u_of;
  logic [31:0] s_q, s_r, u_q, u_r;

  seq_divider #(.SIGNED(1'b1)) u_dut_s (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(s_start), .dividend_i(s_a), .divisor_i(s_b),
    .busy_o(s_busy), .done_o(s_done), .quotient_o(s_q), .remainder_o(s_r),
    .dz_o(s_dz), .of_o(s_of)
  );

  seq_divider #(.SIGNED(1'b0)) u_dut_u (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(u_start), .dividend_i(u_a), .divisor_i(u_b),
    .busy_o(u_busy), .done_o(u_done), .quotient_o(u_q), .remainder_o(u_r),
    .dz_o(u_dz), .of_o(u_of)
  );

  exp_t exp_s[$];
  exp_t exp_u[$];
  int n_cmp = 0;
  int n_bad = 0;
  int unsigned bs_cnt = 0, bu_cnt = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h required 0x%08h", name, act, req);
    end
  endfunction

  function automatic exp_t model(bit sgn, logic [31:0] a, logic [31:0] b);
    exp_t e;
    e.dz = 1'b0; e.of = 1'b0; e.lat = 34; e.e0 = 0;
    if (b == 0) begin
      e.q = 32'hFFFF_FFFF; e.r = a; e.dz = 1'b1; e.lat = 1;
    end else if (sgn) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        e.q = 32'h8000_0000; e.r = 0; e.of = 1'b1;
      end else begin
        e.q = $signed(a) / $signed(b);
        e.r = $signed(a) % $signed(b);
      end
    end else begin
      e.q = a / b;
      e.r = a % b;
    end
    return e;
  endfunction

  function automatic void cmp_res(string t, exp_t e, logic [31:0] q, logic [31:0] r,
                                  logic dz, logic of, int unsigned bc);
    chk({t, "_quotient"}, q, e.q);
    chk({t, "_remainder"}, r, e.r);
    chk({t, "_dz"}, {31'b0, dz}, {31'b0, e.dz});
    chk({t, "_of"}, {31'b0, of}, {31'b0, e.of});
    chk({t, "_latency"}, cyc - e.e0, e.lat);
    chk({t, "_busy_cycles"}, bc, e.lat);
  endfunction

  always @(negedge clk) begin
    if (!rst_n) bs_cnt = 0;
    else begin
      if (s_busy) bs_cnt++;
      if (s_done) begin
        if (exp_s.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL s_unexpected_done: got done with q=0x%08h, required no done", s_q);
        end else cmp_res("s", exp_s.pop_front(), s_q, s_r, s_dz, s_of, bs_cnt);
        bs_cnt = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst_n) bu_cnt = 0;
    else begin
      if (u_busy) bu_cnt++;
      if (u_done) begin
        if (exp_u.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL u_unexpected_done: got done with q=0x%08h, required no done", u_q);
        end else cmp_res("u", exp_u.pop_front(), u_q, u_r, u_dz, u_of, bu_cnt);
        bu_cnt = 0;
      end
    end
  end

  // Drive one request for a single edge; the expectation is queued only when push is set.
  task automatic issue(bit uns, logic [31:0] a, logic [31:0] b, bit push);
    exp_t e;
    @(negedge clk);
    if (uns) begin u_a = a; u_b = b; u_start = 1'b1; end
    else     begin s_a = a; s_b = b; s_start = 1'b1; end
    @(posedge clk); #1;
    e = model(!uns, a, b);
    e.e0 = cyc;
    if (push) begin
      if (uns) exp_u.push_back(e); else exp_s.push_back(e);
    end
    u_start = 1'b0;
    s_start = 1'b0;
  endtask

  task automatic wait_done();
    int k;
    for (k = 0; k < 200; k++) begin
      @(negedge clk);
      if (exp_s.size() == 0 && exp_u.size() == 0) break;
    end
    if (k == 200) begin
      n_cmp++; n_bad++;
      $display("FAIL done_timeout: got %0d/%0d outstanding, required 0/0", exp_s.size(), exp_u.size());
      exp_s.delete();
      exp_u.delete();
    end
  endtask

  task automatic check_zero(string t);
    chk({t, "_busy"}, {31'b0, s_busy}, 32'd0);
    chk({t, "_done"}, {31'b0, s_done}, 32'd0);
    chk({t, "_quotient"}, s_q, 32'd0);
    chk({t, "_remainder"}, s_r, 32'd0);
    chk({t, "_dz"}, {31'b0, s_dz}, 32'd0);
    chk({t, "_of"}, {31'b0, s_of}, 32'd0);
  endtask

  initial begin
    exp_t e;
    logic [31:0] a, b;
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;

    issue(1'b0, 32'd100, 32'd7, 1'b1);                  wait_done();
    issue(1'b0, 32'hFFFF_FF9C, 32'd7, 1'b1);            wait_done();
    issue(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);    wait_done();
    issue(1'b0, 32'h1234_5678, 32'd0, 1'b1);            wait_done();
    issue(1'b1, 32'hFFFF_FFFF, 32'h10, 1'b1);           wait_done();
    issue(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);    wait_done();

    // start held through PREP and DONE of a divide-by-zero must be accepted once.
    @(negedge clk);
    s_a = 32'hDEAD_BEEF; s_b = 32'd0; s_start = 1'b1;
    @(posedge clk); #1;
    e = model(1'b1, s_a, s_b); e.e0 = cyc; exp_s.push_back(e);
    @(posedge clk); @(posedge clk); #1;
    s_start = 1'b0;
    wait_done();
    repeat (3) @(negedge clk);

    // Request during busy is ignored.
    issue(1'b0, 32'd1000, 32'd10, 1'b1);
    repeat (10) @(negedge clk);
    s_a = 32'd5; s_b = 32'd1; s_start = 1'b1;
    @(posedge clk); #1;
    s_start = 1'b0;
    wait_done();

    // Reset mid-operation clears everything at once.
    issue(1'b0, 32'd50, 32'd3, 1'b0);
    repeat (14) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_zero("abort");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    issue(1'b0, 32'd50, 32'd3, 1'b1);                   wait_done();

    for (int i = 0; i < 50; i++) begin
      a = $urandom;
      case ($urandom_range(0, 4))
        0: b = $urandom;
        1: b = ($urandom_range(0, 1) != 0) ? -$urandom_range(1, 20) : $urandom_range(1, 20);
        2: b = 32'd0;
        3: begin a = 32'h8000_0000; b = ($urandom_range(0, 1) != 0) ? 32'hFFFF_FFFF : $urandom; end
        default: begin b = $urandom; a = b >> $urandom_range(1, 8); end
      endcase
      issue(i[0], a, b, 1'b1);
      wait_done();
    end

    repeat (40) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
